// File: rtl/peripheral_spram_pkg.sv
// Shared constants and types for the single-port RAM request controller.
package peripheral_spram_pkg;

    // RAM read data appears this many cycles after the read strobe.
    localparam int SPRAM_RD_LAT = 1;
    // Response buffer depth: read latency plus one slot for back-pressure.
    localparam int SPRAM_RSP_DEPTH = 2;
    // Inactive levels of the active-low RAM strobes.
    localparam logic [1:0] SPRAM_WEN_NONE = 2'b11;
    localparam logic       SPRAM_CEN_OFF  = 1'b1;

    // Default geometry of the peripheral RAM.
    localparam int SPRAM_AW = 6;
    localparam int SPRAM_DW = 16;

    // One master request as seen on the request channel.
    typedef struct packed {
        logic                we;
        logic [1:0]          be;
        logic [SPRAM_AW-1:0] addr;
        logic [SPRAM_DW-1:0] wdata;
    } spram_req_t;

endpackage : peripheral_spram_pkg

// File: rtl/peripheral_spram_rsp_fifo.sv
// Small register FIFO that holds RAM read data until the master takes it.
// The head entry is a plain register read, so it stays stable while the
// consumer stalls. The caller guarantees no push into a full FIFO and no
// pop from an empty one.
module peripheral_spram_rsp_fifo
    import peripheral_spram_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = SPRAM_RSP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic [DW-1:0]              head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [PW-1:0]            wr_q, wr_d;
    logic [PW-1:0]            rd_q, rd_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = mem_q[rd_q];

endmodule : peripheral_spram_rsp_fifo

// File: rtl/peripheral_spram_req_ctrl.sv
// Request-side front end for the single-port RAM.
// Handshakes: a transfer happens on a channel when valid & ready are both
// high at the ram_clk edge; valid holders keep their payload stable until
// then. req_ready depends combinationally on req_we and rsp_ready.
// Reads are admitted only while a slot is guaranteed for their data, so
// response back-pressure can never drop RAM output. Writes produce no
// response and are never stalled.
module peripheral_spram_req_ctrl
    import peripheral_spram_pkg::*;
#(
    parameter int AW        = 6,
    parameter int DW        = 16,
    parameter int RSP_DEPTH = SPRAM_RSP_DEPTH
) (
    input  logic          ram_clk,
    input  logic          ram_rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_be,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    input  logic [DW-1:0] ram_dout
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          acc;
    logic          rsp_pop;
    logic          credit_ok;
    logic [CW:0]   occ_after;
    logic [CW-1:0] q_cnt;
    logic          rd_pend_q, rd_pend_d;

    assign acc     = req_valid & req_ready;
    assign rsp_pop = rsp_valid & rsp_ready;

    // Reads admitted so far but not yet handed back, after this cycle's pop.
    // A new read is allowed only if that leaves room for its data.
    always_comb begin
        occ_after = {1'b0, q_cnt} + {{CW{1'b0}}, rd_pend_q} - {{CW{1'b0}}, rsp_pop};
        credit_ok = (occ_after < (CW+1)'(RSP_DEPTH));
    end

    // Nothing is accepted while reset is held.
    assign req_ready = ram_rstn & (req_we | credit_ok);

    // RAM strobes are driven straight from the request in its accept cycle.
    always_comb begin
        ram_cen = SPRAM_CEN_OFF;
        ram_wen = SPRAM_WEN_NONE;
        if (acc) begin
            if (req_we) begin
                // A write with no byte lanes is accepted but leaves the RAM idle.
                ram_cen = ~(|req_be);
                ram_wen = ~req_be;
            end else begin
                ram_cen = 1'b0;
            end
        end
    end

    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    // Marks the cycle in which the RAM output carries read data.
    always_comb begin
        rd_pend_d = acc & ~req_we;
    end

    // Read-pending register.
    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    peripheral_spram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (ram_clk),
        .rst_n     (ram_rstn),
        .push      (rd_pend_q),
        .push_data (ram_dout),
        .pop       (rsp_pop),
        .cnt       (q_cnt),
        .head      (rsp_rdata)
    );

    assign rsp_valid = (q_cnt != '0);

endmodule : peripheral_spram_req_ctrl

// File: tb/tb_peripheral_spram_req_ctrl.sv
// Bench for the RAM request controller with a behavioural RAM attached.
// The reference model tracks memory contents and the list of reads still
// owed to the master, and predicts handshakes and strobes from those.
module tb_peripheral_spram_req_ctrl;

    localparam int AW = 6;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req_valid, req_ready, req_we;
    logic [1:0]    req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_cen;
    logic [1:0]    ram_wen;
    logic [DW-1:0] ram_dout;

    // rsp_ready source: 0 = low, 1 = high, 2 = random per cycle
    logic [1:0] rsp_mode = 2'd0;
    logic       rand_rdy = 1'b0;
    assign rsp_ready = (rsp_mode == 2'd2) ? rand_rdy : rsp_mode[0];

    always @(posedge clk) begin
        #1 rand_rdy = ($urandom_range(0, 3) != 0);
    end

    peripheral_spram_req_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(2)) dut (
        .ram_clk   (clk),
        .ram_rstn  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_dout  (ram_dout)
    );

    // ---------------- behavioural single-port RAM ----------------
    logic [DW-1:0] ram_mem [64];
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) ram_mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= ram_mem[ram_addr];
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q[$];
    bit            just_rd = 1'b0;   // read admitted at the most recent edge
    bit            acc_exp = 1'b0;
    bit            pop_exp = 1'b0;

    // Predict and compare every cycle, away from the active edge.
    always @(negedge clk) begin
        bit   exp_valid;
        bit   exp_rdy;
        logic exp_cen;
        logic [1:0] exp_wen;
        int   owed;
        if (!rst_n) begin
            acc_exp = 1'b0;
            pop_exp = 1'b0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
            check("rst_ram_cen",   32'(ram_cen),   32'd1);
            check("rst_ram_wen",   32'(ram_wen),   32'd3);
        end else begin
            owed      = exp_q.size();
            exp_valid = (owed - int'(just_rd)) > 0;
            pop_exp   = exp_valid && rsp_ready;
            exp_rdy   = req_we || ((owed - int'(pop_exp)) < 2);
            acc_exp   = req_valid && exp_rdy;
            exp_cen   = !(acc_exp && (!req_we || req_be != 2'b00));
            exp_wen   = (acc_exp && req_we) ? ~req_be : 2'b11;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0]));
            check("ram_cen", 32'(ram_cen), 32'(exp_cen));
            check("ram_wen", 32'(ram_wen), 32'(exp_wen));
            if (acc_exp) check("ram_addr", 32'(ram_addr), 32'(req_addr));
            if (acc_exp && req_we) check("ram_din", 32'(ram_din), 32'(req_wdata));
            check("q_cnt_le2", 32'(dut.u_rsp_fifo.cnt <= 2'd2), 32'd1);
        end
    end

    // Advance the model at each edge using the predicted handshakes.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            just_rd = 1'b0;
        end else begin
            if (pop_exp) void'(exp_q.pop_front());
            just_rd = 1'b0;
            if (acc_exp) begin
                if (req_we) begin
                    if (req_be[0]) ref_mem[req_addr][7:0]  = req_wdata[7:0];
                    if (req_be[1]) ref_mem[req_addr][15:8] = req_wdata[15:8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    just_rd = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 2'b00;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic we, input logic [1:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int waits);
        logic rdy;
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        waits     = 0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
    endtask

    // Let all owed responses drain, then confirm the queue is empty.
    task automatic drain();
        idle();
        rsp_mode = 2'd1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_empty", 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int stalls;
        logic [DW-1:0] old9;
        idle();
        req_addr  = '0;
        req_wdata = '0;
        rsp_mode  = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then back-to-back read of the same word.
        rsp_mode = 2'd1;
        send(1'b1, 2'b11, 6'h05, 16'hA5C3, w);
        send(1'b0, 2'b00, 6'h05, 16'h0000, w);
        idle();
        @(posedge clk);
        #1;
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_rdata", 32'(rsp_rdata), 32'hA5C3);
        drain();

        // Low-byte-only write merges with the existing word.
        req_valid = 1'b1; req_we = 1'b1; req_be = 2'b01;
        req_addr  = 6'h05; req_wdata = 16'hFF11;
        @(negedge clk);
        check("t2_wen", 32'(ram_wen), 32'd2);
        check("t2_cen", 32'(ram_cen), 32'd0);
        @(posedge clk);
        #1;
        send(1'b0, 2'b00, 6'h05, 16'h0000, w);
        idle();
        @(posedge clk);
        #1;
        check("t2_rdata", 32'(rsp_rdata), 32'hA511);
        drain();

        // Fill all words, then stream reads across the full address range.
        for (int a = 0; a < 64; a++) send(1'b1, 2'b11, AW'(a), DW'($urandom), w);
        stalls = 0;
        for (int a = 0; a < 64; a++) begin
            send(1'b0, 2'b00, AW'(a), 16'h0000, w);
            stalls += w;
        end
        send(1'b0, 2'b00, 6'h00, 16'h0000, w);
        stalls += w;
        check("t3_no_stall", 32'(stalls), 32'd0);
        drain();

        // Back-pressure: two reads fit, the third waits, writes still pass.
        rsp_mode = 2'd0;
        send(1'b0, 2'b00, 6'h01, 16'h0000, w);
        check("t4_rd1_wait", 32'(w), 32'd0);
        send(1'b0, 2'b00, 6'h02, 16'h0000, w);
        check("t4_rd2_wait", 32'(w), 32'd0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h03;
        repeat (3) begin
            @(negedge clk);
            check("t4_rd_blocked", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 2'b11, 6'h07, 16'h1234, w);
        check("t4_wr_pass", 32'(w), 32'd0);
        rsp_mode = 2'd1;
        send(1'b0, 2'b00, 6'h03, 16'h0000, w);
        drain();

        // Write with no byte enables touches nothing and returns nothing.
        old9 = ref_mem[9];
        req_valid = 1'b1; req_we = 1'b1; req_be = 2'b00;
        req_addr  = 6'h09; req_wdata = ~old9;
        @(negedge clk);
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_cen", 32'(ram_cen), 32'd1);
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        send(1'b0, 2'b00, 6'h09, 16'h0000, w);
        idle();
        @(posedge clk);
        #1;
        check("t5_unchanged", 32'(rsp_rdata), 32'(old9));
        drain();

        // Reset with one read queued and one in flight, and a write pending.
        rsp_mode = 2'd0;
        send(1'b0, 2'b00, 6'h0A, 16'h0000, w);
        send(1'b0, 2'b00, 6'h0B, 16'h0000, w);
        req_valid = 1'b1; req_we = 1'b1; req_be = 2'b11;
        req_addr  = 6'h0C; req_wdata = 16'hDEAD;
        #1;
        check("t6_pre_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_ram_cen", 32'(ram_cen), 32'd1);
        check("t6_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_q_cnt", 32'(dut.u_rsp_fifo.cnt), 32'd0);
        rsp_mode = 2'd1;
        send(1'b0, 2'b00, 6'h0C, 16'h0000, w);
        send(1'b0, 2'b00, 6'h0B, 16'h0000, w);
        drain();

        // Randomized mix of traffic with random response back-pressure.
        rsp_mode = 2'd2;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 63)), DW'($urandom), w);
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on the run in case a wait is never satisfied.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_peripheral_spram_req_ctrl
